// File: rtl/branch_target_buffer_pkg.sv
// Shared constants and counter helper for the direct-mapped branch target buffer.
package branch_target_buffer_pkg;

  localparam int BTB_INDEX_W = 6;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Saturating step toward taken (up=1) or not-taken (up=0).
  function automatic logic [1:0] sat_ctr_next(input logic [1:0] c, input logic up);
    if (up) return (c == CTR_ST)  ? c : c + 2'd1;
    else    return (c == CTR_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating up/down counter next-state logic used by the BTB update path.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);

  assign nxt = sat_ctr_next(ctr, up);

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: combinational IF lookup,
// EX-stage training, and branch/mispredict statistics.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W,
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        predict_f,
  output logic [31:0] predict_pc,
  input  logic        br_ex,
  input  logic        br_taken,
  input  logic [31:0] pc_ex_br,
  input  logic [31:0] br_target,
  input  logic        pred_ex,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];

  // Instruction addresses are word aligned; the low two bits carry no information.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_if[1:0], pc_ex_br[1:0]};

  logic [INDEX_W-1:0] idx_f, idx_u;
  logic [TAG_W-1:0]   tag_f, tag_u;
  logic               hit_f, hit_u;
  logic [1:0]         ctr_nxt;

  assign idx_f = pc_if[INDEX_W+1:2];
  assign tag_f = pc_if[31:INDEX_W+2];
  assign idx_u = pc_ex_br[INDEX_W+1:2];
  assign tag_u = pc_ex_br[31:INDEX_W+2];

  assign hit_f = valid[idx_f] && (tag[idx_f] == tag_f);
  assign hit_u = valid[idx_u] && (tag[idx_u] == tag_u);

  // Lookup sees pre-update contents; writes land at the clock edge.
  assign predict_f  = hit_f & ctr[idx_f][1];
  assign predict_pc = hit_f ? target[idx_f] : 32'h0;

  sat_counter2 u_sat (
    .ctr (ctr[idx_u]),
    .up  (br_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_WNT;
    end else if (br_ex) begin
      if (hit_u) begin
        ctr[idx_u] <= ctr_nxt;
      end else if (br_taken) begin
        valid[idx_u] <= 1'b1;
        ctr[idx_u]   <= CTR_WT;
      end
    end
  end

  // Tag/target payload needs no reset: it is qualified by valid.
  always_ff @(posedge clk) begin
    if (br_ex && br_taken) begin
      target[idx_u] <= br_target;
      if (!hit_u) tag[idx_u] <= tag_u;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (br_ex) begin
      br_cnt <= br_cnt + 32'd1;
      if (pred_ex != br_taken) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        predict_f;
  logic [31:0] predict_pc;
  logic        br_ex;
  logic        br_taken;
  logic [31:0] pc_ex_br;
  logic [31:0] br_target;
  logic        pred_ex;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  branch_target_buffer dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .predict_f(predict_f),
    .predict_pc(predict_pc), .br_ex(br_ex), .br_taken(br_taken),
    .pc_ex_br(pc_ex_br), .br_target(br_target), .pred_ex(pred_ex),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pf;
    logic [31:0] ppc;
    logic [31:0] bc;
    logic [31:0] mc;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: a table of 64 entries keyed by word index, strength 0..3.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_str   [64];
  logic [31:0] m_bc, m_mc;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return pc / 256;
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_str[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_update(input bit ex, input bit tk, input logic [31:0] pc,
                              input logic [31:0] tgt, input bit pe);
    int i;
    if (!ex) return;
    i = midx(pc);
    if (mhit(pc)) begin
      if (tk) begin
        m_str[i] = (m_str[i] < 3) ? m_str[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_str[i] = (m_str[i] > 0) ? m_str[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1;
      m_tag[i]   = mtag(pc);
      m_tgt[i]   = tgt;
      m_str[i]   = 2;
    end
    m_bc = m_bc + 1;
    if (pe != tk) m_mc = m_mc + 1;
  endtask

  task automatic push_exp(input logic [31:0] pcif, input string name);
    exp_t e;
    e.pf   = mhit(pcif) && (m_str[midx(pcif)] >= 2);
    e.ppc  = mhit(pcif) ? m_tgt[midx(pcif)] : 32'h0;
    e.bc   = m_bc;
    e.mc   = m_mc;
    e.name = name;
    q.push_back(e);
  endtask

  // One fetch/EX cycle: drive after the edge, expect pre-update lookup, then train model.
  task automatic cyc(input bit ex, input bit tk, input logic [31:0] pcex,
                     input logic [31:0] tgt, input bit pe, input logic [31:0] pcif,
                     input string name);
    @(posedge clk);
    #1;
    br_ex = ex; br_taken = tk; pc_ex_br = pcex; br_target = tgt; pred_ex = pe;
    pc_if = pcif;
    push_exp(pcif, name);
    model_update(ex, tk, pcex, tgt, pe);
  endtask

  task automatic look(input logic [31:0] pcif, input string name);
    cyc(1'b0, $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), pcif, name);
  endtask

  task automatic chk(input string name, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "predict_f", {31'b0, predict_f}, {31'b0, e.pf});
      chk(e.name, "predict_pc", predict_pc, e.ppc);
      chk(e.name, "br_cnt", br_cnt, e.bc);
      chk(e.name, "miss_cnt", miss_cnt, e.mc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rpc, ipc;
    rst_n = 1'b0; br_ex = 0; br_taken = 0; pc_ex_br = 0; br_target = 0; pred_ex = 0;
    pc_if = 32'h40;
    model_reset();
    #1 push_exp(32'h40, "reset");
    @(posedge clk); #1 rst_n = 1'b1;

    cyc(1, 1, 32'h40, 32'h100, 0, 32'h40, "alloc_same");
    look(32'h40, "alloc_hit");
    cyc(1, 0, 32'h40, 32'h999, 0, 32'h40, "hyst_nt");
    look(32'h40, "hyst_wnt");
    cyc(1, 1, 32'h40, 32'h100, 0, 32'h40, "hyst_t1");
    cyc(1, 1, 32'h40, 32'h100, 1, 32'h40, "hyst_t2");
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h40, 32'h100, 1, 32'h40, "sat_st");
    cyc(1, 0, 32'h40, 32'h0, 1, 32'h40, "sat_dec");
    look(32'h40, "sat_after");
    cyc(1, 1, 32'h140, 32'h200, 0, 32'h40, "alias_upd");
    look(32'h40, "alias_old");
    look(32'h140, "alias_new");
    cyc(1, 0, 32'h80, 32'h555, 0, 32'h80, "nt_absent");
    look(32'h80, "nt_absent_chk");
    cyc(0, 1, 32'h80, 32'h777, 1, 32'h80, "no_ex");
    look(32'h80, "no_ex_chk");
    cyc(1, 1, 32'h300, 32'h400, 0, 32'h300, "rw_same");
    look(32'h301, "rw_next");

    // Counter wrap: preload br_cnt at its maximum.
    @(posedge clk); #1;
    force dut.br_cnt = 32'hFFFF_FFFF;
    #1 release dut.br_cnt;
    m_bc = 32'hFFFF_FFFF;
    cyc(1, 0, 32'h80, 32'h0, 0, 32'h140, "wrap_pre");
    look(32'h140, "wrap_post");

    // Random traffic over a small PC pool so indices alias and counters saturate.
    for (int n = 0; n < 400; n++) begin
      rpc = {22'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
      ipc = {22'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), rpc, $urandom,
          $urandom_range(0, 1), ipc, "random");
    end

    // Asynchronous reset between edges, with an update pending.
    cyc(1, 1, 32'h140, 32'h200, 0, 32'h140, "pre_reset");
    look(32'h140, "pre_reset_hit");
    @(posedge clk); #2;
    br_ex = 1; br_taken = 1; pc_ex_br = 32'h140; pc_if = 32'h140;
    rst_n = 1'b0;
    model_reset();
    push_exp(32'h140, "async_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    br_ex = 0;
    for (int i = 0; i < 32; i++) look(32'h0000_0000 + 32'(i * 4) + 32'(($urandom_range(0, 3)) * 256), "post_reset");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drain actual=%0d required=0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
